// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared types, constants and helpers for the GF(2^M) digit-serial multiplier
//
// Contents:
//   gf_mult_state_t : controller state encoding {IDLE, CALC, DONE}
//   GF163_M         : NIST B-163 field degree
//   GF163_POLY      : low 163 bits of x^163 + x^7 + x^6 + x^3 + 1 (x^163 implicit)
//   gf_num_digits   : number of D-bit digits needed to cover M bits, ceil(M/D)
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gf_mult_state_t;

    localparam int GF163_M = 163;
    localparam logic [162:0] GF163_POLY = 163'hC9;

    function automatic int gf_num_digits(input int m, input int d);
        return (m + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf_digit_step.sv
// rtl/gf_digit_step.sv - one combinational digit step of the MSB-first GF(2^M) multiplier
//
// Computes acc_next = (acc * x^D mod f) XOR (a_r * digit mod f), where f = x^M + poly.
//
// Ports:
//   acc      in  M  running accumulator
//   a_r      in  M  latched operand A
//   digit    in  D  current digit of B, bit i is the coefficient of x^i
//   poly     in  M  low M bits of the reduction polynomial
//   acc_next out M  reduced accumulator after this digit
module gf_digit_step #(
    parameter int M = 163,
    parameter int D = 4
) (
    input  logic [M-1:0] acc,
    input  logic [M-1:0] a_r,
    input  logic [D-1:0] digit,
    input  logic [M-1:0] poly,
    output logic [M-1:0] acc_next
);

    // Multiply by x and reduce: the bit shifted out of x^(M-1) folds back as poly.
    function automatic logic [M-1:0] mul_x(input logic [M-1:0] v, input logic [M-1:0] p);
        return (v << 1) ^ (v[M-1] ? p : '0);
    endfunction

    logic [M-1:0] shifted;
    logic [M-1:0] a_pow;
    logic [M-1:0] partial;

    always_comb begin
        shifted = acc;
        a_pow   = a_r;
        partial = '0;
        for (int i = 0; i < D; i++) begin
            shifted = mul_x(shifted, poly);
        end
        // a_pow walks through A*x^i mod f; each set digit bit selects one term.
        for (int i = 0; i < D; i++) begin
            if (digit[i]) begin
                partial = partial ^ a_pow;
            end
            a_pow = mul_x(a_pow, poly);
        end
        acc_next = shifted ^ partial;
    end

endmodule

// File: rtl/gf_digit_mult.sv
// rtl/gf_digit_mult.sv - digit-serial GF(2^M) polynomial-basis multiplier with interleaved reduction
//
// Consumes D bits of B per clock, MSB first; the product is fully reduced when done fires.
// Optional build macro GF_DIGIT_MULT_RUNTIME_POLY_EN adds a poly input latched on start,
// otherwise the reduction polynomial is the constant parameter POLY.
//
// Ports:
//   clk     in  1  clock, rising edge
//   n_rst   in  1  asynchronous active-low reset
//   start   in  1  request, sampled only in IDLE
//   a       in  M  operand A, sampled on the accepted start
//   b       in  M  operand B, sampled on the accepted start
//   poly    in  M  (GF_DIGIT_MULT_RUNTIME_POLY_EN only) low M bits of f, sampled on start
//   busy    out 1  high while in CALC or DONE
//   done    out 1  one-cycle pulse, product valid from this cycle
//   product out M  A*B mod f, held until the next operation completes
module gf_digit_mult
    import gf_pkg::*;
#(
    parameter int           M    = GF163_M,
    parameter int           D    = 4,
    parameter logic [M-1:0] POLY = GF163_POLY
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
`ifdef GF_DIGIT_MULT_RUNTIME_POLY_EN
    input  logic [M-1:0] poly,
`endif
    output logic         busy,
    output logic         done,
    output logic [M-1:0] product
);

    localparam int K  = gf_num_digits(M, D);
    localparam int KD = K * D;
    localparam int CW = $clog2(K + 1);

    gf_mult_state_t state;
    gf_mult_state_t state_next;

    logic [M-1:0]  a_r;
    logic [M-1:0]  acc;
    logic [M-1:0]  acc_next;
    logic [M-1:0]  poly_use;
    logic [KD-1:0] b_r;
    logic [CW-1:0] cnt;
    logic          last_digit;

`ifdef GF_DIGIT_MULT_RUNTIME_POLY_EN
    logic [M-1:0] poly_r;
    assign poly_use = poly_r;
`else
    assign poly_use = POLY;
`endif

    assign last_digit = (cnt == CW'(K - 1));

    gf_digit_step #(
        .M(M),
        .D(D)
    ) u_step (
        .acc      (acc),
        .a_r      (a_r),
        .digit    (b_r[KD-1 -: D]),
        .poly     (poly_use),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
`ifdef GF_DIGIT_MULT_RUNTIME_POLY_EN
            poly_r  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        // Zero padding sits above the MSB so it is consumed first and adds nothing.
                        b_r    <= KD'(b);
                        acc    <= '0;
                        cnt    <= '0;
`ifdef GF_DIGIT_MULT_RUNTIME_POLY_EN
                        poly_r <= poly;
`endif
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    b_r <= b_r << D;
                    cnt <= cnt + 1'b1;
                    if (last_digit) begin
                        product <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_gf_digit_mult.sv
// tb/tb_gf_digit_mult.sv - self-checking bench for gf_digit_mult over D in {1,4,7,163}
module tb_gf_digit_mult;

    localparam int M = 163;
    localparam int NI = 4;
    localparam int DV [NI] = '{1, 4, 7, 163};
    localparam logic [M-1:0] DEF_POLY = 163'hC9;
    localparam logic [M-1:0] ALT_POLY = 163'h107;
    localparam int N_RAND = 120;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic           start = 1'b0;
    logic [M-1:0]   a_in = '0;
    logic [M-1:0]   b_in = '0;
    logic [M-1:0]   poly_in = DEF_POLY;
    logic [NI-1:0]  busy_v;
    logic [NI-1:0]  done_v;
    logic [M-1:0]   prod [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int lat [NI];
    int pulses [NI];
    int busy_cnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gf_digit_mult #(
            .M(M),
            .D(DV[g])
        ) u_dut (
            .clk     (clk),
            .n_rst   (n_rst),
            .start   (start),
            .a       (a_in),
            .b       (b_in),
`ifdef GF_DIGIT_MULT_RUNTIME_POLY_EN
            .poly    (poly_in),
`endif
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .product (prod[g])
        );
    end

    typedef struct {
        string        name;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] exp;
    } vec_t;

    vec_t tv [6];

    // Full carry-less product followed by long division by f, top term first.
    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y,
                                             input logic [M-1:0] p);
        logic [2*M-2:0] full;
        logic [2*M-2:0] f;
        full = '0;
        f = (2*M-1)'({1'b1, p});
        for (int i = 0; i < M; i++) begin
            if (y[i]) full = full ^ ((2*M-1)'(x) << i);
        end
        for (int j = 2*M-2; j >= M; j--) begin
            if (full[j]) full = full ^ (f << (j - M));
        end
        return full[M-1:0];
    endfunction

    function automatic logic [M-1:0] rand_fe();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[M-1:0];
    endfunction

    function automatic int exp_lat(input int g);
        return (M + DV[g] - 1) / DV[g] + 1;
    endfunction

    task automatic check_fe(input string name, input logic [M-1:0] got, input logic [M-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Issues one start to every instance, then records done latency (edges counted from the
    // start-sampling edge, inclusive), done pulse counts and busy cycles of the D=4 instance.
    task automatic run_op(input logic [M-1:0] av, input logic [M-1:0] bv, input logic [M-1:0] pv);
        int  edges;
        bit  all_done;
        @(negedge clk);
        a_in = av;
        b_in = bv;
        poly_in = pv;
        start = 1'b1;
        for (int g = 0; g < NI; g++) begin
            lat[g] = -1;
            pulses[g] = 0;
        end
        busy_cnt = 0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        a_in = rand_fe();
        b_in = rand_fe();
        poly_in = rand_fe();
        for (int cyc = 0; cyc < 400; cyc++) begin
            all_done = 1'b1;
            for (int g = 0; g < NI; g++) begin
                if (done_v[g]) begin
                    pulses[g]++;
                    if (lat[g] < 0) lat[g] = edges;
                end
                if (lat[g] < 0 || done_v[g]) all_done = 1'b0;
            end
            if (busy_v[1]) busy_cnt++;
            if (all_done) break;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string name, input logic [M-1:0] exp);
        for (int g = 0; g < NI; g++) begin
            check_fe($sformatf("%s D=%0d product", name, DV[g]), prod[g], exp);
            check_int($sformatf("%s D=%0d latency", name, DV[g]), lat[g], exp_lat(g));
            check_int($sformatf("%s D=%0d done pulses", name, DV[g]), pulses[g], 1);
        end
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [M-1:0] one;
        logic [M-1:0] ones;
        logic [M-1:0] a1, b1, a2, b2, ra, rb;
        int edges;
        int dcount;
        bit seen;

        one  = 1;
        ones = '1;
        tv[0] = '{"one_x_one",    one,        one,        one};
        tv[1] = '{"x162_x_x",     one << 162, 163'h2,     163'hC9};
        tv[2] = '{"x2p1_x_xp1",   163'h5,     163'h3,     163'hF};
        tv[3] = '{"zero_x_ones",  '0,         ones,       '0};
        tv[4] = '{"x162_x_x2",    one << 162, 163'h4,     163'h192};
        tv[5] = '{"x162_x_one",   one << 162, one,        one << 162};

        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check_fe($sformatf("reset D=%0d product", DV[g]), prod[g], '0);
        end
        check_int("reset busy", int'(busy_v), 0);
        check_int("reset done", int'(done_v), 0);
        n_rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(tv[i].a, tv[i].b, DEF_POLY);
            check_op(tv[i].name, tv[i].exp);
            check_int({tv[i].name, " D=4 busy cycles"}, busy_cnt, 42);
        end

        // start held high across an operation: only the first operand pair counts, and the
        // next request is taken the cycle after done.
        a1 = rand_fe(); b1 = rand_fe(); a2 = rand_fe(); b2 = rand_fe();
        @(negedge clk);
        poly_in = DEF_POLY;
        a_in = a1; b_in = b1; start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        a_in = a2; b_in = b2;
        seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            if (done_v[1]) seen = 1'b1;
            else begin
                @(posedge clk); edges++; @(negedge clk);
            end
        end
        check_int("hold D=4 first latency", edges, 42);
        check_fe("hold D=4 first product", prod[1], ref_mul(a1, b1, DEF_POLY));
        @(posedge clk); @(negedge clk);
        check_int("hold D=4 idle after done", int'(busy_v[1]), 0);
        @(posedge clk); @(negedge clk);
        check_int("hold D=4 restart accepted", int'(busy_v[1]), 1);
        start = 1'b0;
        dcount = 0;
        for (int cyc = 0; cyc < 100 && dcount == 0; cyc++) begin
            if (done_v[1]) dcount++;
            else begin
                @(posedge clk); @(negedge clk);
            end
        end
        check_int("hold D=4 second done seen", dcount, 1);
        check_fe("hold D=4 second product", prod[1], ref_mul(a2, b2, DEF_POLY));
        repeat (200) @(negedge clk);

        // Reset in the middle of CALC.
        @(negedge clk);
        a_in = rand_fe(); b_in = rand_fe(); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_int("pre-reset D=4 busy", int'(busy_v[1]), 1);
        n_rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check_fe($sformatf("midreset D=%0d product", DV[g]), prod[g], '0);
        end
        check_int("midreset busy", int'(busy_v), 0);
        check_int("midreset done", int'(done_v), 0);
        @(negedge clk);
        n_rst = 1'b1;
        dcount = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (done_v != '0) dcount++;
        end
        check_int("post-reset spurious done", dcount, 0);
        ra = rand_fe(); rb = rand_fe();
        run_op(ra, rb, DEF_POLY);
        check_op("after reset", ref_mul(ra, rb, DEF_POLY));
        check_int("after reset D=4 busy cycles", busy_cnt, 42);

        for (int i = 0; i < N_RAND; i++) begin
            ra = rand_fe(); rb = rand_fe();
            run_op(ra, rb, DEF_POLY);
            check_op($sformatf("rand%0d", i), ref_mul(ra, rb, DEF_POLY));
        end

`ifdef GF_DIGIT_MULT_RUNTIME_POLY_EN
        for (int i = 0; i < N_RAND; i++) begin
            ra = rand_fe(); rb = rand_fe();
            run_op(ra, rb, ALT_POLY);
            check_op($sformatf("altpoly%0d", i), ref_mul(ra, rb, ALT_POLY));
        end
`else
        ra = ref_mul(one << 162, 163'h2, ALT_POLY);
        check_fe("model alt poly wrap", ra, ALT_POLY);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
